// File: rtl/ycbcr_pkg.sv
// Shared constants and pixel type for the YCbCr <-> RGB converters.
// Coefficients are Q8 (value * 256) full-range BT.601.
package ycbcr_pkg;

  localparam int C_RCR  = 359;
  localparam int C_GCB  = 88;
  localparam int C_GCR  = 183;
  localparam int C_BCB  = 454;

  localparam int OFFSET = 128;
  localparam int ROUND  = 128;
  localparam int FRAC   = 8;

  localparam int LANES  = 16;
  localparam int PIXW   = 24;
  localparam int PIPE   = 4;

  // hi/mid/lo carry Y/Cb/Cr on input and R/G/B on output.
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] mid;
    logic [7:0] lo;
  } pix_t;

  // Add half an LSB and drop the fraction; the integer part fits 11 signed bits.
  function automatic logic signed [10:0] round_q8(input logic signed [18:0] s);
    logic signed [18:0] t;
    t = (s + 19'(ROUND)) >>> FRAC;
    return t[10:0];
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [10:0] v);
    if (v < 0) return 8'h00;
    if (v > 11'sd255) return 8'hFF;
    return v[7:0];
  endfunction

endpackage

// File: rtl/ycbcr_rgb_if.sv
// Beat bus between the upstream pipeline and the YCbCr->RGB converter.
interface ycbcr_rgb_if;
  import ycbcr_pkg::*;

  // start qualifies d_in on the same edge; there is no ready, so every beat is
  // taken, and all_end qualifies d_out for exactly one cycle with no stall.
  logic                      start;
  logic [LANES*PIXW-1:0]     d_in;
  logic                      all_end;
  logic [LANES*PIXW-1:0]     d_out;
  logic                      busy;

  modport master (output start, d_in, input all_end, d_out, busy);
  modport slave  (input start, d_in, output all_end, d_out, busy);
endinterface

// File: rtl/ycbcr_rgb_lane.sv
// One pixel of the YCbCr->RGB inverse: offset, multiply, round, clamp.
module ycbcr_rgb_lane
  import ycbcr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  pix_t pix_in,
  output pix_t pix_out
);

  localparam logic signed [18:0] K_RCR = 19'(C_RCR);
  localparam logic signed [18:0] K_GCB = 19'(C_GCB);
  localparam logic signed [18:0] K_GCR = 19'(C_GCR);
  localparam logic signed [18:0] K_BCB = 19'(C_BCB);

  logic signed [18:0] yq_s1;
  logic signed [8:0]  cb_s1, cr_s1;
  logic signed [18:0] yq_s2, p_rcr, p_gcb, p_gcr, p_bcb;
  logic signed [10:0] r_s3, g_s3, b_s3;

  // Stages run every cycle; only the top-level output load is qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yq_s1   <= '0;
      cb_s1   <= '0;
      cr_s1   <= '0;
      yq_s2   <= '0;
      p_rcr   <= '0;
      p_gcb   <= '0;
      p_gcr   <= '0;
      p_bcb   <= '0;
      r_s3    <= '0;
      g_s3    <= '0;
      b_s3    <= '0;
      pix_out <= '0;
    end else begin
      yq_s1   <= {3'b000, pix_in.hi, 8'h00};
      cb_s1   <= 9'({1'b0, pix_in.mid}) - 9'(OFFSET);
      cr_s1   <= 9'({1'b0, pix_in.lo}) - 9'(OFFSET);

      yq_s2   <= yq_s1;
      p_rcr   <= K_RCR * 19'(cr_s1);
      p_gcb   <= K_GCB * 19'(cb_s1);
      p_gcr   <= K_GCR * 19'(cr_s1);
      p_bcb   <= K_BCB * 19'(cb_s1);

      r_s3    <= round_q8(yq_s2 + p_rcr);
      g_s3    <= round_q8(yq_s2 - p_gcb - p_gcr);
      b_s3    <= round_q8(yq_s2 + p_bcb);

      pix_out <= '{hi: clamp8(r_s3), mid: clamp8(g_s3), lo: clamp8(b_s3)};
    end
  end

endmodule

// File: rtl/ycbcr_rgb.sv
// 16-lane YCbCr 4:4:4 -> RGB888 converter with a shared valid pipeline.
module ycbcr_rgb
  import ycbcr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ycbcr_rgb_if.slave  bus
);

  logic [PIPE-1:0]           vld;
  logic                      all_end_q;
  logic [LANES*PIXW-1:0]     d_out_q;
  logic [LANES*PIXW-1:0]     lane_bus;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pix_t lane_out;
    ycbcr_rgb_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .pix_in  (bus.d_in[k*PIXW +: PIXW]),
      .pix_out (lane_out)
    );
    assign lane_bus[k*PIXW +: PIXW] = lane_out;
  end

  // vld[PIPE-1] lines up with the lane output register; d_out holds between beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      all_end_q <= 1'b0;
      d_out_q   <= '0;
    end else begin
      vld       <= {vld[PIPE-2:0], bus.start};
      all_end_q <= vld[PIPE-1];
      if (vld[PIPE-1]) d_out_q <= lane_bus;
    end
  end

  assign bus.all_end = all_end_q;
  assign bus.d_out   = d_out_q;
  assign bus.busy    = |vld;

endmodule

// File: tb/tb_ycbcr_rgb.sv
// Bench for ycbcr_rgb: arithmetic reference model, per-cycle compare, directed and random beats.
module tb_ycbcr_rgb;
  import ycbcr_pkg::*;

  localparam int W = LANES * PIXW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ycbcr_rgb_if bus ();
  ycbcr_rgb dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic         exp_ae   = 1'b0;
  logic [W-1:0] exp_dout = '0;

  function automatic int floor256(input int v);
    return (v >= 0) ? v / 256 : -((255 - v) / 256);
  endfunction

  function automatic logic [7:0] sat(input int v);
    return (v < 0) ? 8'd0 : (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic logic [23:0] ref_pix(input logic [23:0] p);
    int y, cb, cr;
    y  = int'(p[23:16]);
    cb = int'(p[15:8]) - 128;
    cr = int'(p[7:0]) - 128;
    return {sat(floor256(y * 256 + 359 * cr + 128)),
            sat(floor256(y * 256 - 88 * cb - 183 * cr + 128)),
            sat(floor256(y * 256 + 454 * cb + 128))};
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*PIXW +: PIXW] = ref_pix(d[k*PIXW +: PIXW]);
    return r;
  endfunction

  function automatic logic [W-1:0] fill(input logic [23:0] p);
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*PIXW +: PIXW] = p;
    return r;
  endfunction

  // A beat sampled on edge e appears on the output after edge e+4.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      exp_ae = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        exp_dout = exp_q.pop_front();
        exp_ae   = 1'b1;
      end
      if (bus.start) begin
        due_q.push_back(cyc + 4);
        exp_q.push_back(ref_beat(bus.d_in));
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      due_q.delete();
      exp_q.delete();
      exp_ae   = 1'b0;
      exp_dout = '0;
    end
    chk("all_end", W'(bus.all_end), W'(exp_ae));
    chk("busy", W'(bus.busy), W'(due_q.size() != 0));
    chk("d_out", bus.d_out, exp_dout);
  end

  // ---------------- driver tasks ----------------
  task automatic start_beat(input logic [W-1:0] d);
    bus.start = 1'b1;
    bus.d_in  = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Returns negedges waited (5 == sampled edge + 4) and the busy-high count seen.
  task automatic wait_end(output logic [W-1:0] d, output int lat, output int busy_n);
    lat = -1; busy_n = 0; d = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.all_end) begin
        lat = i;
        d   = bus.d_out;
        break;
      end
    end
    if (lat < 0) chk("wait_timeout", W'(0), W'(1));
  endtask

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] r;
    int sel;
    for (int k = 0; k < LANES; k++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       r[k*PIXW +: PIXW] = 24'h000000;
        1:       r[k*PIXW +: PIXW] = 24'hFFFFFF;
        2:       r[k*PIXW +: PIXW] = {8'($urandom), 16'h8080};
        default: r[k*PIXW +: PIXW] = 24'($urandom);
      endcase
    end
    return r;
  endfunction

  // ---------------- stimulus ----------------
  logic [W-1:0] d, e0, e1;
  int lat, busy_n, seen;

  initial begin
    bus.start = 1'b0;
    bus.d_in  = '0;

    chk("model_gray",  W'(ref_pix(24'h808080)), W'(24'h808080));
    chk("model_red",   W'(ref_pix(24'h4C55FF)), W'(24'hFE0000));
    chk("model_white", W'(ref_pix(24'hFFFFFF)), W'(24'hFF79FF));
    chk("model_black", W'(ref_pix(24'h000000)), W'(24'h008800));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // single beat, latency and busy width
    start_beat(fill(24'h808080));
    wait_end(d, lat, busy_n);
    chk("gray_out", d, fill(24'h808080));
    chk("gray_latency_edges", W'(lat - 1), W'(4));
    chk("gray_busy_cycles", W'(busy_n), W'(4));
    @(negedge clk);
    chk("gray_single_cycle", W'(bus.all_end), W'(0));
    @(posedge clk); #1;

    start_beat(fill(24'h4C55FF));
    wait_end(d, lat, busy_n);
    chk("red_out", d, fill(24'hFE0000));
    @(posedge clk); #1;

    // alternating clamp lanes
    for (int k = 0; k < LANES; k++) begin
      e0[k*PIXW +: PIXW] = (k % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      e1[k*PIXW +: PIXW] = (k % 2 == 0) ? 24'hFF79FF : 24'h008800;
    end
    start_beat(e0);
    wait_end(d, lat, busy_n);
    chk("clamp_out", d, e1);
    @(posedge clk); #1;

    // three back-to-back beats
    bus.start = 1'b1;
    bus.d_in = fill(24'h808080); @(posedge clk); #1;
    bus.d_in = fill(24'h4C55FF); @(posedge clk); #1;
    bus.d_in = fill(24'hFFFFFF); @(posedge clk); #1;
    bus.start = 1'b0;
    wait_end(d, lat, busy_n);
    chk("b2b_first", d, fill(24'h808080));
    @(negedge clk);
    chk("b2b_second_valid", W'(bus.all_end), W'(1));
    chk("b2b_second", bus.d_out, fill(24'hFE0000));
    @(negedge clk);
    chk("b2b_third_valid", W'(bus.all_end), W'(1));
    chk("b2b_third", bus.d_out, fill(24'hFF79FF));
    repeat (3) @(negedge clk);
    chk("b2b_hold", bus.d_out, fill(24'hFF79FF));
    @(posedge clk); #1;

    // lane independence
    for (int k = 0; k < LANES; k++) begin
      e0[k*PIXW +: PIXW] = {8'(k * 16), 16'h8080};
      e1[k*PIXW +: PIXW] = {3{8'(k * 16)}};
    end
    start_beat(e0);
    wait_end(d, lat, busy_n);
    chk("lane_indep", d, e1);
    @(posedge clk); #1;

    // reset mid-flight
    start_beat(fill(24'h808080));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.all_end) seen++;
    end
    chk("rst_no_end", W'(seen), W'(0));
    chk("rst_dout", bus.d_out, '0);
    chk("rst_busy", W'(bus.busy), W'(0));
    @(posedge clk); #1;
    start_beat(fill(24'h4C55FF));
    wait_end(d, lat, busy_n);
    chk("post_rst_out", d, fill(24'hFE0000));
    chk("post_rst_latency_edges", W'(lat - 1), W'(4));
    @(posedge clk); #1;

    // random traffic, checked every cycle by the compare process
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 3) != 0);
      bus.d_in  = rand_beat();
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", W'(due_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
